pipelined_adder: RTL
====================

// Module: pipelined_adder
// PURPOSE
//  Parametrised WIDTH-bit add/subtract unit whose carry chain is split into STAGES
//  register-separated chunks; a chunk's carry is handed to the next stage each cycle.
//  Valid/ready on both sides with backpressure; flags cout, signed overflow, zero.
//  Sits beside the ALU for wide or multi-cycle arithmetic (address gen, counters).
// PARAMETERS
//  WIDTH   32  operand/result width in bits; must be a multiple of STAGES
//  STAGES  4   pipeline depth = latency in cycles; chunk CW = WIDTH/STAGES bits (1..WIDTH)
// PORTS
//  clk        in   1      rising-edge clock, single clock domain
//  rst_n      in   1      synchronous active-low reset (sampled on clk rising edge)
//  in_valid   in   1      operand beat valid
//  in_ready   out  1      unit can accept a beat this cycle
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  cin        in   1      carry in (add only)
//  sub        in   1      1: A - B, 0: A + B + cin
//  sat        in   1      request signed saturation (used only with PIPE_ADD_SAT_EN)
//  out_valid  out  1      result beat valid
//  out_ready  in   1      downstream accepts result
//  sum        out  WIDTH  result
//  cout       out  1      carry out of bit WIDTH-1 (sub: 1 = no borrow)
//  overflow   out  1      signed overflow of the operation
//  zero       out  1      sum == 0 (after saturation, if any)
// BEHAVIOUR
//  - Reset (rst_n=0 at clk edge): all stage valid bits, out_valid, sum, cout, overflow,
//    zero cleared to 0; in-flight beats dropped. in_ready=1 the first cycle after reset.
//  - Effective operand: bx = sub ? ~b : b; carry in c0 = sub ? 1 : cin (cin ignored on sub).
//  - Stage k (0..STAGES-1) adds chunk k of a and bx plus carry from stage k-1 (c0 for k=0),
//    registers CW sum bits, its carry out, and forwards untouched higher chunks/flags.
//  - Last stage registers sum, cout; overflow = (a[W-1]==bx[W-1]) & (sum[W-1]!=a[W-1]).
//  - Global stall: adv = ~out_valid | out_ready; in_ready = adv (combinational).
//    adv=1: every stage shifts one step, stage 0 loads a beat iff in_valid.
//    adv=0: all stage registers hold; outputs stable while out_valid & ~out_ready.
//  - Handshake: input transfer when in_valid & in_ready; output transfer when
//    out_valid & out_ready. Beats never reordered, duplicated or dropped (except reset).
//  - Latency: exactly STAGES cycles from input transfer to out_valid with no stall;
//    throughput 1 beat/cycle. Bubbles propagate (not collapsed).
//  - Simultaneous output transfer and input transfer in one cycle: both occur.
//  - Wrap-around: result is modulo 2^WIDTH; 0xFFFFFFFF + 1 -> sum 0, cout 1, zero 1.
//  - STAGES=1: single registered adder, latency 1. CW=1 legal (bit-serial carry chain).
//  - Non-multiple WIDTH/STAGES: elaboration error via generate-time check.
// CONFIGURATION
//  PIPE_ADD_SAT_EN defined: when sat=1 at input transfer and overflow occurs, sum clamps
//    to 0x7FF..F (positive overflow) or 0x800..0 (negative); overflow still reported 1;
//    zero computed on clamped value; cout unchanged. Latency unchanged.
//  PIPE_ADD_SAT_EN undefined: sat ignored, result always wraps; no extra logic.
// TESTING (WIDTH=32, STAGES=4 unless noted)
//  1 Reset: rst_n=0 two cycles with in_valid=1 -> out_valid=0, sum=0, flags=0; in_ready=1 after.
//  2 Latency/stream: a=0x0000FFFF,b=1,cin=0 then 8 back-to-back beats, out_ready=1 ->
//    first out_valid exactly 4 cycles after transfer, sum=0x00010000 (carry crosses chunk),
//    one result per cycle in order.
//  3 Sub/flags: a=5,b=5,sub=1 -> sum=0, zero=1, cout=1; a=0x80000000,b=1,sub=1 ->
//    sum=0x7FFFFFFF, overflow=1, cout=1.
//  4 Backpressure: fill pipe, out_ready=0 for 6 cycles -> in_ready=0, sum stable, no beat
//    lost; release -> results resume in order, one per cycle.
//  5 Reset mid-operation: 3 beats in flight, rst_n=0 one cycle -> none of them emerge.
//  6 Saturation (PIPE_ADD_SAT_EN): a=0x7FFFFFFF,b=1,sat=1 -> sum=0x7FFFFFFF, overflow=1;
//    macro off -> sum=0x80000000, overflow=1. Repeat case 2 with STAGES=1 and STAGES=32.

Source files
------------

// File: rtl/pipelined_adder.sv
// WIDTH-bit add/subtract whose carry chain is cut into STAGES registered chunks, with
// valid/ready handshake and a global stall. Define PIPE_ADD_SAT_EN for signed saturation.
module pipelined_adder #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    input  logic             sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             zero
);

    localparam int unsigned CW = WIDTH / STAGES;

    if ((WIDTH % STAGES) != 0) begin : g_param_err
        $error("pipelined_adder: WIDTH must be a multiple of STAGES");
    end

    logic                         adv;
    logic [STAGES-1:0]            st_v;
    logic [STAGES-1:0]            st_c;
    logic [STAGES-1:0][WIDTH-1:0] st_a;
    logic [STAGES-1:0][WIDTH-1:0] st_bx;
    logic [STAGES-1:0][WIDTH-1:0] st_s;
    logic                         ovf_q;
    logic                         zero_q;
`ifdef PIPE_ADD_SAT_EN
    logic [STAGES-1:0]            st_sat;
`else
    logic                         unused_sat;
    assign unused_sat = sat;
`endif

    // One stall signal for the whole pipe: every stage moves or none does.
    assign adv       = ~st_v[STAGES-1] | out_ready;
    assign in_ready  = adv;
    assign out_valid = st_v[STAGES-1];
    assign sum       = st_s[STAGES-1];
    assign cout      = st_c[STAGES-1];
    assign overflow  = ovf_q;
    assign zero      = zero_q;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [WIDTH-1:0] src_a;
        logic [WIDTH-1:0] src_bx;
        logic [WIDTH-1:0] src_s;
        logic             src_c;
        logic             src_v;
        logic [CW:0]      chunk;
        logic [WIDTH-1:0] new_s;
        logic [WIDTH-1:0] fin_s;
        logic [WIDTH-1:0] a_r;
        logic [WIDTH-1:0] bx_r;
        logic [WIDTH-1:0] s_r;
        logic             c_r;
        logic             v_r;
`ifdef PIPE_ADD_SAT_EN
        logic             src_sat;
        logic             sat_r;
`endif

        if (k == 0) begin : g_src_first
            assign src_a  = a;
            assign src_bx = sub ? ~b : b;
            assign src_s  = '0;
            assign src_c  = sub | cin;
            assign src_v  = in_valid;
`ifdef PIPE_ADD_SAT_EN
            assign src_sat = sat;
`endif
        end else begin : g_src_rest
            assign src_a  = st_a[k-1];
            assign src_bx = st_bx[k-1];
            assign src_s  = st_s[k-1];
            assign src_c  = st_c[k-1];
            assign src_v  = st_v[k-1];
`ifdef PIPE_ADD_SAT_EN
            assign src_sat = st_sat[k-1];
`endif
        end

        assign chunk = {1'b0, src_a[k*CW +: CW]} + {1'b0, src_bx[k*CW +: CW]}
                     + (CW+1)'(src_c);

        always_comb begin
            new_s              = src_s;
            new_s[k*CW +: CW]  = chunk[CW-1:0];
        end

        if (k == STAGES - 1) begin : g_last
            logic ovf_d;

            assign ovf_d = (src_a[WIDTH-1] == src_bx[WIDTH-1])
                         & (new_s[WIDTH-1] != src_a[WIDTH-1]);
`ifdef PIPE_ADD_SAT_EN
            // Both operands share a sign on overflow, so a's sign picks the clamp rail.
            always_comb begin
                fin_s = new_s;
                if (src_sat && ovf_d) begin
                    fin_s = src_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                           : {1'b0, {(WIDTH-1){1'b1}}};
                end
            end
`else
            assign fin_s = new_s;
`endif

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    ovf_q  <= 1'b0;
                    zero_q <= 1'b0;
                end else if (adv && src_v) begin
                    ovf_q  <= ovf_d;
                    zero_q <= (fin_s == '0);
                end
            end
        end else begin : g_mid
            assign fin_s = new_s;
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                v_r   <= 1'b0;
                a_r   <= '0;
                bx_r  <= '0;
                s_r   <= '0;
                c_r   <= 1'b0;
`ifdef PIPE_ADD_SAT_EN
                sat_r <= 1'b0;
`endif
            end else if (adv) begin
                v_r <= src_v;
                if (src_v) begin
                    a_r   <= src_a;
                    bx_r  <= src_bx;
                    s_r   <= fin_s;
                    c_r   <= chunk[CW];
`ifdef PIPE_ADD_SAT_EN
                    sat_r <= src_sat;
`endif
                end
            end
        end

        assign st_v[k]  = v_r;
        assign st_a[k]  = a_r;
        assign st_bx[k] = bx_r;
        assign st_s[k]  = s_r;
        assign st_c[k]  = c_r;
`ifdef PIPE_ADD_SAT_EN
        assign st_sat[k] = sat_r;
`endif
    end

    // Operands are forwarded whole; the last stage's copy has no consumer.
    logic unused_tail;
`ifdef PIPE_ADD_SAT_EN
    assign unused_tail = ^{st_a[STAGES-1], st_bx[STAGES-1], st_sat[STAGES-1]};
`else
    assign unused_tail = ^{st_a[STAGES-1], st_bx[STAGES-1]};
`endif

endmodule
